// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI control register block: register byte
// offsets, STATUS/CTRL bit positions, count-field geometry and the transfer
// sequencer state encoding.
// -----------------------------------------------------------------------------
package spi_pkg;

  // Register byte offsets on the 4-bit bus address
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_RXDATA = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  // STATUS bit positions
  localparam int STAT_BUSY       = 0;
  localparam int STAT_TX_FULL    = 1;
  localparam int STAT_TX_EMPTY   = 2;
  localparam int STAT_RX_FULL    = 3;
  localparam int STAT_RX_EMPTY   = 4;
  localparam int STAT_TX_OVF     = 5;
  localparam int STAT_RX_OVF     = 6;
  localparam int STAT_TX_CNT_LSB = 8;
  localparam int STAT_RX_CNT_LSB = 12;
  localparam int CNT_FIELD_W     = 3;

  // CTRL bit positions
  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_CS_FORCE = 1;
  localparam int CTRL_IRQ_EN   = 2;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    SEQ_IDLE      = 2'd0,
    SEQ_LAUNCH    = 2'd1,
    SEQ_WAIT_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/spi_ctrl_regs_if.sv
// -----------------------------------------------------------------------------
// spi_ctrl_regs_if
// Single-cycle register bus between a host (master) and spi_ctrl_regs (slave).
//   bus_sel   : access request, one cycle per access
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : byte offset
//   bus_wdata : write data
//   bus_rdata : registered read data, valid with bus_ack
//   bus_ack   : one-cycle pulse, the cycle after bus_sel
// -----------------------------------------------------------------------------
interface spi_ctrl_regs_if;
  logic        bus_sel;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_sel, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_sel, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Small synchronous FIFO with first-word-fall-through head output.
//   clk, reset : clock, asynchronous active-low reset
//   push, push_data : write request / data (accepted when not full, or when
//                     a pop happens in the same cycle)
//   pop        : remove head entry (ignored when empty)
//   head_data  : current head entry
//   full, empty, count : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_reg != '0);
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          entry_reg <= '0;
        end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= push_data;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  assign head_data = entries[rd_ptr_reg];
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;

endmodule

// File: rtl/spi_ctrl_regs.sv
// -----------------------------------------------------------------------------
// spi_ctrl_regs
// Register front end for a byte-wide SPI shift engine: TX/RX FIFOs, STATUS and
// CTRL registers, and a sequencer that feeds the engine one byte at a time.
//   clk, reset   : clock, asynchronous active-low reset
//   bus_if       : register bus (slave side), offsets TXDATA/RXDATA/STATUS/CTRL
//   eng_start    : one-cycle pulse launching a byte in the shift engine
//   eng_tx_data  : byte to shift out, held from eng_start until eng_done
//   eng_done     : engine finished the byte (ignored unless waiting for it)
//   eng_rx_data  : received byte, valid with eng_done
//   cs_n         : chip select, low while busy or when forced
//   irq          : level interrupt
// -----------------------------------------------------------------------------
module spi_ctrl_regs
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  spi_ctrl_regs_if.slave bus_if,
  output logic           eng_start,
  output logic [7:0]     eng_tx_data,
  input  logic           eng_done,
  input  logic [7:0]     eng_rx_data,
  output logic           cs_n,
  output logic           irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             wr_access;
  logic             rd_access;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_full;
  logic             tx_empty;
  logic [7:0]       tx_head;
  logic [CNT_W-1:0] tx_count;
  logic             rx_push;
  logic             rx_pop;
  logic             rx_full;
  logic             rx_empty;
  logic [7:0]       rx_head;
  logic [CNT_W-1:0] rx_count;
  logic             done_accept;
  logic             status_wr;
  logic             ctrl_wr;
  logic             tx_ovf_set;
  logic             rx_ovf_set;
  logic             busy;

  seq_state_t  state_reg;
  seq_state_t  state_next;
  logic        enable_reg;
  logic        cs_force_reg;
  logic        irq_en_reg;
  logic        tx_ovf_reg;
  logic        rx_ovf_reg;
  logic        ack_reg;
  logic [31:0] rdata_reg;
  logic [31:0] rdata_next;
  logic [7:0]  eng_tx_data_reg;
  logic        unused_wdata;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign wr_access = bus_if.bus_sel && bus_if.bus_we;
  assign rd_access = bus_if.bus_sel && !bus_if.bus_we;
  assign tx_push   = wr_access && (bus_if.bus_addr == OFF_TXDATA);
  assign rx_pop    = rd_access && (bus_if.bus_addr == OFF_RXDATA);
  assign status_wr = wr_access && (bus_if.bus_addr == OFF_STATUS);
  assign ctrl_wr   = wr_access && (bus_if.bus_addr == OFF_CTRL);
  assign unused_wdata = ^bus_if.bus_wdata[31:8];

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (bus_if.bus_wdata[7:0]),
    .pop       (tx_pop),
    .head_data (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (eng_rx_data),
    .pop       (rx_pop),
    .head_data (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // A received byte is dropped if RX is full when the engine reports it,
  // regardless of a same-cycle bus pop.
  assign rx_push    = done_accept && !rx_full;
  assign rx_ovf_set = done_accept && rx_full;
  // TX push to a full FIFO only drops when the sequencer is not popping.
  assign tx_ovf_set = tx_push && tx_full && !tx_pop;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= SEQ_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    tx_pop      = 1'b0;
    done_accept = 1'b0;
    case (state_reg)
      SEQ_IDLE: begin
        if (enable_reg && !tx_empty && !rx_full) state_next = SEQ_LAUNCH;
      end
      SEQ_LAUNCH: begin
        tx_pop     = 1'b1;
        state_next = SEQ_WAIT_DONE;
      end
      SEQ_WAIT_DONE: begin
        if (eng_done) begin
          done_accept = 1'b1;
          state_next  = SEQ_IDLE;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  // Capture the head on the way into LAUNCH so the byte is already valid
  // while eng_start is high; the head cannot change before the pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_tx_data_reg <= '0;
    end else if ((state_reg == SEQ_IDLE) && (state_next == SEQ_LAUNCH)) begin
      eng_tx_data_reg <= tx_head;
    end
  end

  assign busy        = (state_reg != SEQ_IDLE);
  assign eng_start   = (state_reg == SEQ_LAUNCH);
  assign eng_tx_data = eng_tx_data_reg;
  assign cs_n        = !(busy || cs_force_reg);
  assign irq         = irq_en_reg && (!rx_empty || tx_ovf_reg || rx_ovf_reg);

  // ---------------------------------------------------------------------------
  // CTRL and sticky overflow flags (a new overflow wins over a same-cycle clear)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_reg   <= 1'b0;
      cs_force_reg <= 1'b0;
      irq_en_reg   <= 1'b0;
      tx_ovf_reg   <= 1'b0;
      rx_ovf_reg   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable_reg   <= bus_if.bus_wdata[CTRL_ENABLE];
        cs_force_reg <= bus_if.bus_wdata[CTRL_CS_FORCE];
        irq_en_reg   <= bus_if.bus_wdata[CTRL_IRQ_EN];
      end
      if (tx_ovf_set) tx_ovf_reg <= 1'b1;
      else if (status_wr && bus_if.bus_wdata[STAT_TX_OVF]) tx_ovf_reg <= 1'b0;
      if (rx_ovf_set) rx_ovf_reg <= 1'b1;
      else if (status_wr && bus_if.bus_wdata[STAT_RX_OVF]) rx_ovf_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and bus response
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_next = '0;
    case (bus_if.bus_addr)
      OFF_RXDATA: begin
        if (!rx_empty) rdata_next = {24'h0, rx_head};
      end
      OFF_STATUS: begin
        rdata_next[STAT_BUSY]     = busy;
        rdata_next[STAT_TX_FULL]  = tx_full;
        rdata_next[STAT_TX_EMPTY] = tx_empty;
        rdata_next[STAT_RX_FULL]  = rx_full;
        rdata_next[STAT_RX_EMPTY] = rx_empty;
        rdata_next[STAT_TX_OVF]   = tx_ovf_reg;
        rdata_next[STAT_RX_OVF]   = rx_ovf_reg;
        rdata_next[STAT_TX_CNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(tx_count);
        rdata_next[STAT_RX_CNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(rx_count);
      end
      OFF_CTRL: begin
        rdata_next[CTRL_ENABLE]   = enable_reg;
        rdata_next[CTRL_CS_FORCE] = cs_force_reg;
        rdata_next[CTRL_IRQ_EN]   = irq_en_reg;
      end
      default: rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ack_reg <= bus_if.bus_sel;
      if (rd_access) rdata_reg <= rdata_next;
    end
  end

  assign bus_if.bus_ack   = ack_reg;
  assign bus_if.bus_rdata = rdata_reg;

endmodule
